// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// hazard_fwd_unit : load-use stall control and EX operand forwarding selects.
// Define HFU_WB_FWD_EN to enable MEM/WB forwarding; otherwise stall instead.
// Rev 1.0
// ============================================================================
module hazard_fwd_unit #(
  parameter int LOAD_STALL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] id_dest,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       flush,
  output logic       stall,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [4:0] ex_dest,
  output logic [4:0] mem_dest,
  output logic [4:0] wb_dest,
  output logic       wb_regwrite
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [1:0] C_HOLD_CNT = 2'(LOAD_STALL - 1);

  state_t     r_state;
  logic [1:0] r_cnt;

  logic [4:0] r_ex_rs, r_ex_rt, r_ex_dest;
  logic       r_ex_regwrite, r_ex_memread;
  logic [4:0] r_mem_dest, r_wb_dest;
  logic       r_mem_regwrite, r_wb_regwrite;

  logic       w_load_hazard;
  logic       w_mem_hazard;
  logic       w_stall;

  // Selects the youngest producer of a source register; $0 never matches.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic       mem_rw,
                                         input logic [4:0] mem_d,
                                         input logic       wb_rw,
                                         input logic [4:0] wb_d);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_rw && (mem_d != 5'd0) && (mem_d == src))
      sel = 2'b01;
`ifdef HFU_WB_FWD_EN
    else if (wb_rw && (wb_d != 5'd0) && (wb_d == src))
      sel = 2'b10;
`else
    else if (wb_rw && (wb_d == src) && 1'b0)
      sel = 2'b00;
`endif
    return sel;
  endfunction

  assign w_load_hazard = r_ex_memread && r_ex_regwrite && (r_ex_dest != 5'd0) &&
                         ((id_rs == r_ex_dest) || (id_rt == r_ex_dest));

`ifdef HFU_WB_FWD_EN
  assign w_mem_hazard = 1'b0;
`else
  // Without the WB path the reader waits until the producer writes the regfile.
  assign w_mem_hazard = r_mem_regwrite && (r_mem_dest != 5'd0) &&
                        ((id_rs == r_mem_dest) || (id_rt == r_mem_dest));
`endif

  always_comb begin
    w_stall = 1'b0;
    if (!flush) begin
      if (r_state == ST_HOLD)
        w_stall = 1'b1;
      else
        w_stall = w_load_hazard || w_mem_hazard;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else if (flush) begin
      r_state <= ST_RUN;
      r_cnt   <= 2'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_load_hazard && (LOAD_STALL > 1)) begin
            r_state <= ST_HOLD;
            r_cnt   <= C_HOLD_CNT;
          end
        end
        ST_HOLD: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1)
            r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_rs        <= 5'd0;
      r_ex_rt        <= 5'd0;
      r_ex_dest      <= 5'd0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_dest     <= 5'd0;
      r_mem_regwrite <= 1'b0;
      r_wb_dest      <= 5'd0;
      r_wb_regwrite  <= 1'b0;
    end else begin
      r_mem_dest     <= r_ex_dest;
      r_mem_regwrite <= r_ex_regwrite;
      r_wb_dest      <= r_mem_dest;
      r_wb_regwrite  <= r_mem_regwrite;
      if (w_stall || flush) begin
        r_ex_rs       <= 5'd0;
        r_ex_rt       <= 5'd0;
        r_ex_dest     <= 5'd0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
      end else begin
        r_ex_rs       <= id_rs;
        r_ex_rt       <= id_rt;
        r_ex_dest     <= id_dest;
        r_ex_regwrite <= id_regwrite;
        r_ex_memread  <= id_memread;
      end
    end
  end

  assign stall       = w_stall;
  assign fwd_a       = fwd_sel(r_ex_rs, r_mem_regwrite, r_mem_dest, r_wb_regwrite, r_wb_dest);
  assign fwd_b       = fwd_sel(r_ex_rt, r_mem_regwrite, r_mem_dest, r_wb_regwrite, r_wb_dest);
  assign ex_dest     = r_ex_dest;
  assign mem_dest    = r_mem_dest;
  assign wb_dest     = r_wb_dest;
  assign wb_regwrite = r_wb_regwrite;

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_fwd_unit : directed vector table plus multi-cycle hazard sequences.
// Rev 1.0
// ============================================================================
module tb_hazard_fwd_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_regwrite, id_memread, flush;

  logic       st1, st3;
  logic [1:0] fa1, fb1, fa3, fb3;
  logic [4:0] exd1, memd1, wbd1, exd3, memd3, wbd3;
  logic       wbrw1, wbrw3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.LOAD_STALL(1)) dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(st1), .fwd_a(fa1), .fwd_b(fb1), .ex_dest(exd1), .mem_dest(memd1),
    .wb_dest(wbd1), .wb_regwrite(wbrw1)
  );

  hazard_fwd_unit #(.LOAD_STALL(3)) dut3 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
    .stall(st3), .fwd_a(fa3), .fwd_b(fb3), .ex_dest(exd3), .mem_dest(memd3),
    .wb_dest(wbd3), .wb_regwrite(wbrw3)
  );

  typedef struct {
    logic [4:0] rs, rt, dest;
    logic       rw, mr;
    logic       st;
    logic [1:0] fa, fb;
    logic [4:0] exd, memd, wbd;
    logic       wbrw;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic [4:0] rs, rt, dest, input logic rw, mr, st,
                              input logic [1:0] fa, fb, input logic [4:0] exd, memd, wbd,
                              input logic wbrw);
    vec_t v;
    v.rs = rs; v.rt = rt; v.dest = dest; v.rw = rw; v.mr = mr; v.st = st;
    v.fa = fa; v.fb = fb; v.exd = exd; v.memd = memd; v.wbd = wbd; v.wbrw = wbrw;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Drive ID inputs at the falling edge, then let combinational outputs settle.
  task automatic drive(input logic [4:0] rs, rt, dest, input logic rw, mr, fl, rst);
    @(negedge clk);
    id_rs = rs; id_rt = rt; id_dest = dest;
    id_regwrite = rw; id_memread = mr; flush = fl; reset = rst;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; id_rs = 0; id_rt = 0; id_dest = 0;
    id_regwrite = 0; id_memread = 0; flush = 0;

    //           rs rt  d rw mr st fa fb exd memd wbd wbrw
    vecs[0]  = mk(1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(3, 5, 4, 1, 0, 0, 0, 0, 3, 0, 0, 0);
    vecs[2]  = mk(1, 1, 3, 1, 0, 0, 1, 0, 4, 3, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 4, 3, 1);
`ifdef HFU_WB_FWD_EN
    vecs[4]  = mk(3, 3, 6, 1, 0, 0, 0, 0, 0, 3, 4, 1);
    vecs[5]  = mk(3, 3, 6, 1, 0, 0, 2, 2, 6, 0, 3, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 6, 0, 0);
    vecs[7]  = mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 6, 6, 1);
`else
    vecs[4]  = mk(3, 3, 6, 1, 0, 1, 0, 0, 0, 3, 4, 1);
    vecs[5]  = mk(3, 3, 6, 1, 0, 0, 0, 0, 0, 0, 3, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0, 0);
    vecs[7]  = mk(1, 2, 0, 1, 0, 0, 0, 0, 0, 6, 0, 0);
`endif
    vecs[8]  = mk(0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 6, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 1);
    vecs[11] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5, 1);
    vecs[12] = mk(0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state of both instances.
    do_reset();
    chk("rst_stall1", 0, {7'd0, st1}, 8'd0);
    chk("rst_fwd1",   0, {4'd0, fa1, fb1}, 8'd0);
    chk("rst_dest1",  0, {3'd0, exd1} | {3'd0, memd1} | {3'd0, wbd1}, 8'd0);
    chk("rst_wbrw1",  0, {7'd0, wbrw1}, 8'd0);
    chk("rst_stall3", 0, {7'd0, st3}, 8'd0);
    chk("rst_dest3",  0, {3'd0, exd3} | {3'd0, memd3} | {3'd0, wbd3}, 8'd0);

    // Forwarding / $0 vector stream on the LOAD_STALL=1 instance.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].dest, vecs[i].rw, vecs[i].mr, 1'b0, 1'b0);
      chk("vec_stall", i, {7'd0, st1},   {7'd0, vecs[i].st});
      chk("vec_fwd_a", i, {6'd0, fa1},   {6'd0, vecs[i].fa});
      chk("vec_fwd_b", i, {6'd0, fb1},   {6'd0, vecs[i].fb});
      chk("vec_exd",   i, {3'd0, exd1},  {3'd0, vecs[i].exd});
      chk("vec_memd",  i, {3'd0, memd1}, {3'd0, vecs[i].memd});
      chk("vec_wbd",   i, {3'd0, wbd1},  {3'd0, vecs[i].wbd});
      chk("vec_wbrw",  i, {7'd0, wbrw1}, {7'd0, vecs[i].wbrw});
    end

    // lw $2 ; add $7,$2,$1 with LOAD_STALL=1.
    do_reset();
    drive(1, 2, 2, 1, 1, 0, 0);
    chk("l1_s0_stall", 0, {7'd0, st1}, 8'd0);
    drive(2, 1, 7, 1, 0, 0, 0);
    chk("l1_s1_stall", 1, {7'd0, st1}, 8'd1);
    chk("l1_s1_exd",   1, {3'd0, exd1}, 8'd2);
    drive(2, 1, 7, 1, 0, 0, 0);
`ifdef HFU_WB_FWD_EN
    chk("l1_s2_stall", 2, {7'd0, st1}, 8'd0);
`else
    chk("l1_s2_stall", 2, {7'd0, st1}, 8'd1);
`endif
    chk("l1_s2_exd",   2, {3'd0, exd1}, 8'd0);
    chk("l1_s2_memd",  2, {3'd0, memd1}, 8'd2);
`ifdef HFU_WB_FWD_EN
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("l1_s3_stall", 3, {7'd0, st1}, 8'd0);
    chk("l1_s3_fwd_a", 3, {6'd0, fa1}, 8'd2);
    chk("l1_s3_exd",   3, {3'd0, exd1}, 8'd7);
    chk("l1_s3_wbd",   3, {3'd0, wbd1}, 8'd2);
`else
    drive(2, 1, 7, 1, 0, 0, 0);
    chk("l1_s3_stall", 3, {7'd0, st1}, 8'd0);
    chk("l1_s3_exd",   3, {3'd0, exd1}, 8'd0);
    chk("l1_s3_wbd",   3, {3'd0, wbd1}, 8'd2);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("l1_s4_fwd_a", 4, {6'd0, fa1}, 8'd0);
    chk("l1_s4_exd",   4, {3'd0, exd1}, 8'd7);
`endif

    // Same sequence with LOAD_STALL=3: three consecutive stall cycles.
    do_reset();
    drive(1, 2, 2, 1, 1, 0, 0);
    chk("l3_s0_stall", 0, {7'd0, st3}, 8'd0);
    for (int k = 1; k <= 3; k++) begin
      drive(2, 1, 7, 1, 0, 0, 0);
      chk("l3_hold_stall", k, {7'd0, st3}, 8'd1);
    end
    drive(2, 1, 7, 1, 0, 0, 0);
    chk("l3_s4_stall", 4, {7'd0, st3}, 8'd0);
    chk("l3_s4_exd",   4, {3'd0, exd3}, 8'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("l3_s5_exd",   5, {3'd0, exd3}, 8'd7);
    chk("l3_s5_fwd_a", 5, {6'd0, fa3}, 8'd0);

    // Flush in the detection cycle overrides the load-use stall.
    do_reset();
    drive(1, 2, 2, 1, 1, 0, 0);
    drive(2, 1, 7, 1, 0, 1, 0);
    chk("fl_stall1", 1, {7'd0, st1}, 8'd0);
    chk("fl_stall3", 1, {7'd0, st3}, 8'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("fl_exd3",   2, {3'd0, exd3}, 8'd0);
    chk("fl_memd3",  2, {3'd0, memd3}, 8'd2);
    chk("fl_run3",   2, {7'd0, st3}, 8'd0);

    // Reset asserted while the LOAD_STALL=3 instance is holding.
    do_reset();
    drive(1, 2, 2, 1, 1, 0, 0);
    drive(2, 1, 7, 1, 0, 0, 0);
    chk("rh_stall3", 1, {7'd0, st3}, 8'd1);
    drive(2, 1, 7, 1, 0, 0, 1);
    drive(2, 1, 7, 1, 0, 0, 0);
    chk("rh_post_stall3", 3, {7'd0, st3}, 8'd0);
    chk("rh_post_dest3",  3, {3'd0, exd3} | {3'd0, memd3} | {3'd0, wbd3}, 8'd0);
    chk("rh_post_wbrw3",  3, {7'd0, wbrw3}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
